// File: rtl/mem_map_pkg.sv
// Shared types and default geometry for the multi-bank memory map.
// The top derives its own widths from its parameters; these are the defaults.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE
  } state_e;

  localparam int unsigned BANK_BITS   = 3;
  localparam int unsigned ROW_BITS    = 10;
  localparam int unsigned TOTAL_WORDS = 2 ** (BANK_BITS + ROW_BITS);

endpackage

// File: rtl/mem_bank.sv
// One simple-dual-port bank: single write port, registered read-first read port.
// Storage carries no reset so it maps onto block RAM.
module mem_bank
  import mem_map_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both updates are non-blocking, so a same-edge read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bank_array.sv
// NUM_BANKS banks behind one flat address space with zero-fill, streaming
// preload, registered host read with valid, and drop reporting while busy.
module mem_bank_array
  import mem_map_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_DEPTH = 2 ** ROW_BITS,
  parameter int unsigned NUM_BANKS  = 2 ** BANK_BITS,
  parameter int unsigned ADDR_WIDTH = $clog2(TOTAL_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csen,
  input  logic                  clr_start,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  drop
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W  = $clog2(BANK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BANKS * BANK_DEPTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(BANK_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [BANK_W-1:0]     rd_bank_q, rd_bank_d;

  logic                  idle;
  logic                  rd_fire;
  logic                  wr_fire;
  logic [BANK_W-1:0]     rd_bank;
  logic [BANK_W-1:0]     wr_bank;
  logic [BANK_W-1:0]     cnt_bank;

  logic [NUM_BANKS-1:0]  bank_we;
  logic [NUM_BANKS-1:0]  bank_re;
  logic [ROW_W-1:0]      bank_waddr;
  logic [ROW_W-1:0]      bank_raddr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign idle     = (state_q == ST_IDLE);
  assign rd_fire  = rd_en & csen & idle;
  assign wr_fire  = wr_en & csen & idle;
  assign rd_bank  = rd_addr[ADDR_WIDTH-1 -: BANK_W];
  assign wr_bank  = wr_addr[ADDR_WIDTH-1 -: BANK_W];
  assign cnt_bank = cnt_q[ADDR_WIDTH-1 -: BANK_W];

  // Control FSM; cnt_q is the row index in CLEAR and the flat address in LOAD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (load_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q[ROW_W-1:0] == LAST_ROW) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop_d     = csen & (rd_en | wr_en) & ~idle;
    rd_valid_d = rd_fire;
    rd_bank_d  = rd_fire ? rd_bank : rd_bank_q;
  end

  // Only one writer is active per state, so all banks share address and data.
  always_comb begin
    bank_we    = '0;
    bank_re    = '0;
    bank_waddr = wr_addr[ROW_W-1:0];
    bank_wdata = wr_data;
    bank_raddr = rd_addr[ROW_W-1:0];
    unique case (state_q)
      ST_CLEAR: begin
        bank_we    = '1;
        bank_waddr = cnt_q[ROW_W-1:0];
        bank_wdata = '0;
      end
      ST_LOAD: begin
        bank_waddr = cnt_q[ROW_W-1:0];
        bank_wdata = load_data;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          bank_we[b] = load_valid && (cnt_bank == BANK_W'(b));
        end
      end
      default: begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          bank_we[b] = wr_fire && (wr_bank == BANK_W'(b));
        end
      end
    endcase
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_re[b] = rd_fire && (rd_bank == BANK_W'(b));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (BANK_DEPTH),
      .ADDR_W    (ROW_W)
    ) u_bank (
      .clk  (clk),
      .we   (bank_we[b]),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .re   (bank_re[b]),
      .raddr(bank_raddr),
      .rdata(bank_rdata[b])
    );
  end

  // Bank read registers hold stale data when idle, so gate with valid.
  assign rd_data    = rd_valid_q ? bank_rdata[rd_bank_q] : '0;
  assign rd_valid   = rd_valid_q;
  assign drop       = drop_q;
  assign busy       = ~idle;
  assign done       = (state_q == ST_DONE);
  assign load_ready = (state_q == ST_LOAD);

endmodule

// File: tb/tb_mem_bank_array.sv
// Scoreboard bench for mem_bank_array: reads push expected data, a negedge
// monitor pops and compares whenever rd_valid is presented.
module tb_mem_bank_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        csen, clr_start, load_start, load_valid;
  logic [7:0]  load_data;
  logic        load_ready, busy, done;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        drop;

  mem_bank_array #(
    .DATA_WIDTH(8),
    .BANK_DEPTH(1024),
    .NUM_BANKS (8),
    .ADDR_WIDTH(13)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .csen      (csen),
    .clr_start (clr_start),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_pass   = 0;
  int   n_total  = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every presented read must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_total++;
        $display("FAIL %s: got no rd_valid expected data 0x%0h", sb[0].name, sb[0].data);
        void'(sb.pop_front());
      end
      if (rd_valid) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
          check(sb[0].name, {24'd0, rd_data}, {24'd0, sb[0].data});
          void'(sb.pop_front());
        end else begin
          n_total++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 data 0x%0h expected rd_valid=0", rd_data);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [12:0] a, input logic [7:0] e, input string nm);
    exp_t x;
    csen    = 1'b1;
    rd_en   = 1'b1;
    rd_addr = a;
    x.due   = cyc + 1;
    x.data  = e;
    x.name  = nm;
    sb.push_back(x);
  endtask

  // Streams value addr[7:0]^xv with random gaps; stops early when idx hits stop_at.
  task automatic run_load(input logic [7:0] xv, input bit inject, input int stop_at);
    int          idx;
    bit          lv, acc, inj, injected;
    logic [12:0] a;
    idx      = 0;
    injected = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int c = 0; c < 30000 && idx < 8192; c++) begin
      if (stop_at >= 0 && idx == stop_at) return;
      lv         = ($urandom_range(0, 3) != 0);
      a          = idx[12:0];
      load_valid = lv;
      load_data  = a[7:0] ^ xv;
      inj        = inject && !injected && idx == 4000;
      if (inj) begin
        csen    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = 13'd100;
        wr_en   = 1'b1;
        wr_addr = 13'd100;
        wr_data = 8'hEE;
      end
      acc = lv && load_ready;
      tick();
      rd_en = 1'b0;
      wr_en = 1'b0;
      if (acc) idx++;
      if (inj) begin
        injected   = 1'b1;
        load_valid = 1'b0;
        @(negedge clk);
        check("drop_pulse_in_load", {31'd0, drop}, 32'd1);
        @(negedge clk);
        check("drop_single_cycle", {31'd0, drop}, 32'd0);
        tick();
      end
    end
    load_valid = 1'b0;
    check("load_beats_accepted", idx, 32'd8192);
    @(negedge clk);
    check("load_done_pulse", {31'd0, done}, 32'd1);
    check("load_ready_falls", {31'd0, load_ready}, 32'd0);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_load", {31'd0, busy}, 32'd0);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_done"},       {31'd0, done},       32'd0);
    check({tag, "_load_ready"}, {31'd0, load_ready}, 32'd0);
    check({tag, "_rd_valid"},   {31'd0, rd_valid},   32'd0);
    check({tag, "_drop"},       {31'd0, drop},       32'd0);
    check({tag, "_rd_data"},    {24'd0, rd_data},    32'd0);
  endtask

  initial begin
    int nb, nd, nlr, d0;
    rst = 1'b1;
    csen = 1'b0; clr_start = 1'b0; load_start = 1'b0; load_valid = 1'b0;
    load_data = '0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Clear and load requested together: clear wins.
    clr_start  = 1'b1;
    load_start = 1'b1;
    tick();
    clr_start  = 1'b0;
    load_start = 1'b0;
    nb = 0; nd = 0; nlr = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (done) nd++;
      if (load_ready) nlr++;
    end
    check("clear_busy_cycles", nb, 32'd1025);
    check("clear_done_pulses", nd, 32'd1);
    check("clear_no_load_ready", nlr, 32'd0);
    tick();

    issue_read(13'd0,    8'h00, "clr_rd_0");    tick();
    issue_read(13'd5000, 8'h00, "clr_rd_5000"); tick();
    issue_read(13'd8191, 8'h00, "clr_rd_8191"); tick();
    rd_en = 1'b0;
    tick();

    d0 = done_cnt;
    run_load(8'h00, 1'b1, -1);
    check("load_done_count", done_cnt - d0, 32'd1);

    issue_read(13'h1234, 8'h34, "ld_rd_1234"); tick();
    issue_read(13'd8191, 8'hFF, "ld_rd_8191"); tick();
    issue_read(13'd100,  8'h64, "ld_rd_100_not_overwritten"); tick();
    issue_read(13'd0,    8'h00, "ld_rd_0"); tick();
    rd_en = 1'b0;
    tick();

    // Same-cycle write and read to 3000 (0xBB8): read returns old byte.
    csen = 1'b1; wr_en = 1'b1; wr_addr = 13'd3000; wr_data = 8'hA5;
    issue_read(13'd3000, 8'hB8, "rmw_old_value"); tick();
    wr_en = 1'b0;
    issue_read(13'd3000, 8'hA5, "rmw_new_value"); tick();
    rd_en = 1'b0;
    tick();

    // Chip disabled: neither access nor drop.
    csen = 1'b0; rd_en = 1'b1; rd_addr = 13'd3000;
    wr_en = 1'b1; wr_addr = 13'd3000; wr_data = 8'h11;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; csen = 1'b1;
    @(negedge clk);
    check("csen_low_no_drop", {31'd0, drop}, 32'd0);
    tick();
    issue_read(13'd3000, 8'hA5, "csen_low_no_write"); tick();
    rd_en = 1'b0;
    tick();

    // Reset in the middle of a load.
    d0 = done_cnt;
    run_load(8'h00, 1'b0, 4000);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midload_no_done", done_cnt - d0, 32'd0);
    check("midload_idle_after", {31'd0, busy}, 32'd0);

    d0 = done_cnt;
    run_load(8'h5A, 1'b0, -1);
    check("reload_done_count", done_cnt - d0, 32'd1);
    issue_read(13'd0,    8'h5A, "reload_rd_0");    tick();
    issue_read(13'd4001, 8'hFB, "reload_rd_4001"); tick();
    issue_read(13'd8191, 8'hA5, "reload_rd_8191"); tick();
    rd_en = 1'b0;
    repeat (4) tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
